// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: a wide bundle in, one word per beat out.
interface word_serializer_if #(
  parameter int WORD_WIDTH  = 3,
  parameter int INPUT_COUNT = 9,
  parameter int ADDR_WIDTH  = 4
);
  localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT;

  logic                   in_valid;
  logic                   in_ready;
  logic [TOTAL_WIDTH-1:0] words_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_WIDTH-1:0]  word_out;
  logic [ADDR_WIDTH-1:0]  selector;
  logic                   out_last;

  modport master (
    output in_valid, words_in, out_ready,
    input  in_ready, out_valid, word_out, selector, out_last
  );

  modport slave (
    input  in_valid, words_in, out_ready,
    output in_ready, out_valid, word_out, selector, out_last
  );
endinterface

// File: rtl/word_serializer.sv
// Captures a bundle of INPUT_COUNT words and emits them one per output handshake,
// word 0 first; a new bundle may be taken on the last beat without a bubble.
module word_serializer #(
  parameter int WORD_WIDTH  = 3,
  parameter int INPUT_COUNT = 9,
  parameter int ADDR_WIDTH  = 4
) (
  input logic              clock,
  input logic              reset,
  word_serializer_if.slave bus
);
  localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT;
  localparam logic [ADDR_WIDTH-1:0] SEL_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] SEL_ONE  = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] SEL_LAST = ADDR_WIDTH'(INPUT_COUNT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [ADDR_WIDTH-1:0]  sel_r;
  logic [ADDR_WIDTH-1:0]  sel_s;
  logic [TOTAL_WIDTH-1:0] holding_r;
  logic [TOTAL_WIDTH-1:0] holding_s;
  logic                   last_s;
  logic                   in_ready_s;
  logic [WORD_WIDTH-1:0]  word_arr_s [INPUT_COUNT];

  assign last_s = (state_r == SEND) && (sel_r == SEL_LAST);

  // in_ready is forced low while reset is held so no bundle can be offered mid-reset
  assign in_ready_s = !reset && ((state_r == IDLE) || (last_s && bus.out_ready));

  // Slice the holding register into words so the output mux sees registers only
  always_comb begin
    for (int i = 0; i < INPUT_COUNT; i++) begin
      word_arr_s[i] = holding_r[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Next-state, selector and holding-register update
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    holding_s = holding_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          holding_s = bus.words_in;
          sel_s     = SEL_ZERO;
          state_s   = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (last_s) begin
            if (bus.in_valid) begin
              holding_s = bus.words_in;
              sel_s     = SEL_ZERO;
              state_s   = SEND;
            end else begin
              sel_s   = SEL_ZERO;
              state_s = IDLE;
            end
          end else begin
            sel_s = sel_r + SEL_ONE;
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        sel_s   = SEL_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      sel_r     <= SEL_ZERO;
      holding_r <= {TOTAL_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      holding_r <= holding_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == SEND);
  assign bus.out_last  = last_s;
  assign bus.selector  = sel_r;
  assign bus.word_out  = word_arr_s[sel_r];
endmodule
